// File: rtl/fifo_pkg.sv
// Shared definitions for the 16x8 synchronous FIFO and its read-side packer.
package fifo_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_DW    = 8;
  localparam int MAX_BPW    = 8;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_FULL = 1'b1
  } pk_state_t;

  // Thermometer mask with the low cnt bits set; widened by one bit so cnt == MAX_BPW works.
  function automatic logic [MAX_BPW-1:0] keep_mask(input int unsigned cnt);
    logic [MAX_BPW:0] t;
    t = (MAX_BPW+1)'(1) << cnt;
    t = t - (MAX_BPW+1)'(1);
    return t[MAX_BPW-1:0];
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register; contents hold while the consumer stalls.
module stream_out_reg #(
  parameter int W  = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [KW-1:0] load_keep,
  output logic          free,
  output logic [W-1:0]  m_data,
  output logic [KW-1:0] m_keep,
  output logic          m_valid,
  input  logic          m_ready
);

  // Empty, or the held word leaves on this edge.
  assign free = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the FIFO one byte per clock and packs BPW bytes little-endian into a valid/ready word.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int BPW = 4,
  parameter int DW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_wr_en,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [BPW*DW-1:0] m_data,
  output logic [BPW-1:0]    m_keep,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy
);

  localparam int CW = $clog2(BPW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BPW);

  pk_state_t         state, state_nx;
  logic [CW-1:0]     byte_cnt, cnt_cap, cnt_eff;
  logic              inflight, flush_pend;
  logic [BPW*DW-1:0] asm_q, asm_cur;
  logic [BPW-1:0]    word_keep;
  logic              full_done, fl_done, word_rdy, xfer, out_free;
  logic              flush_set, wr_fire, rd_fire;

  // Assembly view including the byte landing this cycle; a completed word can leave
  // on the same edge as its last capture, which is what keeps reads back-to-back.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch.
    asm_cur = asm_q;
    for (int i = 0; i < BPW; i++) begin
      if (inflight && byte_cnt == CW'(i)) asm_cur[i*DW +: DW] = fifo_dout;
    end
    cnt_cap   = byte_cnt + CW'(inflight);
    word_keep = BPW'(keep_mask(32'(cnt_cap)));
  end

  // Output process: word completion, transfer and read strobe.
  always_comb begin
    full_done  = (state == PK_FILL) && inflight && (cnt_cap == CNT_FULL);
    fl_done    = (state == PK_FILL) && flush_pend && !inflight;
    word_rdy   = (state == PK_FULL) || full_done || fl_done;
    xfer       = word_rdy && out_free;
    flush_set  = flush && (state == PK_FILL) && !full_done && ((byte_cnt != '0) || inflight);
    cnt_eff    = xfer ? '0 : cnt_cap;
    wr_fire    = fifo_wr_en && !fifo_full;
    fifo_rd_en = rst && !fifo_empty && (cnt_eff < CNT_FULL) && !(flush_pend && !xfer);
    rd_fire    = fifo_rd_en && !wr_fire;
  end

  // Next-state process: park in FULL only while the output register is occupied.
  always_comb begin
    state_nx = state;
    case (state)
      PK_FILL: if ((full_done || fl_done) && !out_free) state_nx = PK_FULL;
      PK_FULL: if (out_free) state_nx = PK_FILL;
      default: state_nx = PK_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= PK_FILL;
    else      state <= state_nx;
  end

  // NOTE: sequential state uses non-blocking assignments only; the assembly register is
  // reset too, since zero upper lanes are what zero-fill a partial word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt   <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      asm_q      <= '0;
    end else begin
      inflight <= rd_fire;
      if (xfer) begin
        byte_cnt   <= '0;
        flush_pend <= 1'b0;
        asm_q      <= '0;
      end else begin
        byte_cnt   <= cnt_cap;
        flush_pend <= flush_pend || flush_set;
        asm_q      <= asm_cur;
      end
    end
  end

  stream_out_reg #(.W(BPW*DW), .KW(BPW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_data (asm_cur),
    .load_keep (word_keep),
    .free      (out_free),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  assign busy = m_valid || inflight || (byte_cnt != '0) || flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural write-priority FIFO in front, byte/word scoreboards behind.
module tb_fifo_rd_packer;

  localparam int BPW = 4;
  localparam int W   = 8 * BPW;

  logic           clk = 1'b0;
  logic           rst, frst_n;
  logic [7:0]     fifo_dout, din;
  logic           fifo_empty, fifo_full, fifo_wr_en, fifo_rd_en;
  logic           flush, m_valid, m_ready, busy;
  logic [W-1:0]   m_data;
  logic [BPW-1:0] m_keep;

  always #5 clk = ~clk;

  fifo_rd_packer #(.BPW(BPW), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  typedef struct {
    logic [W-1:0]   data;
    logic [BPW-1:0] keep;
  } word_t;

  typedef struct {
    int             n;
    logic [W-1:0]   bytes;
    bit             do_flush;
    logic [W-1:0]   exp_data;
    logic [BPW-1:0] exp_keep;
  } vec_t;

  logic [7:0] sb_bytes[$];
  word_t      exp_words[$];
  int         n_cmp = 0, n_bad = 0, n_words = 0;
  int         rd_run = 0, max_run = 0;

  // FIFO model: 16 deep, registered read data, a write wins over a read.
  logic [7:0] mem[16];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;
  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_full  = (fcnt == 5'd16);

  always @(posedge clk) begin
    if (!frst_n) begin
      wp <= '0; rp <= '0; fcnt <= '0; fifo_dout <= '0;
    end else if (fifo_wr_en && !fifo_full) begin
      mem[wp] <= din; wp <= wp + 4'd1; fcnt <= fcnt + 5'd1;
      sb_bytes.push_back(din);
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rp]; rp <= rp + 4'd1; fcnt <= fcnt - 5'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Output monitor: word scoreboard for directed tests, byte scoreboard always.
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_data;
  logic [BPW-1:0] prev_keep;

  always @(negedge clk) begin
    if (rst && frst_n) begin
      if (fifo_rd_en && !fifo_empty && !(fifo_wr_en && !fifo_full)) rd_run++;
      else rd_run = 0;
      if (rd_run > max_run) max_run = rd_run;
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(prev_data));
        check("hold_keep", 64'(m_keep), 64'(prev_keep));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
      if (m_valid && m_ready) begin
        n_words++;
        check("keep_thermo", 64'((((32'(m_keep) + 1) & 32'(m_keep)) == 0) && (m_keep != '0)), 64'd1);
        if (exp_words.size() != 0) begin
          word_t e;
          e = exp_words.pop_front();
          check("word_data", 64'(m_data), 64'(e.data));
          check("word_keep", 64'(m_keep), 64'(e.keep));
        end
        for (int k = 0; k < BPW; k++) begin
          if (m_keep[k]) begin
            if (sb_bytes.size() == 0) check("byte_extra", 64'(m_data[k*8 +: 8]), 64'hdead);
            else check("byte_stream", 64'(m_data[k*8 +: 8]), 64'(sb_bytes.pop_front()));
          end else begin
            check("zero_fill", 64'(m_data[k*8 +: 8]), 64'd0);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
      rd_run     = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    fifo_wr_en = 1'b1;
    din        = d;
    tick();
    fifo_wr_en = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] d, input logic [BPW-1:0] k);
    word_t w;
    w.data = d;
    w.keep = k;
    exp_words.push_back(w);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while ((busy || fcnt != 0 || exp_words.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    check(name, 64'(i < budget), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];
  int   base;

  initial begin
    vecs[0] = '{n: 3, bytes: 32'h00C3B2A1, do_flush: 1'b1, exp_data: 32'h00C3B2A1, exp_keep: 4'b0111};
    vecs[1] = '{n: 1, bytes: 32'h0000005A, do_flush: 1'b1, exp_data: 32'h0000005A, exp_keep: 4'b0001};
    vecs[2] = '{n: 2, bytes: 32'h0000BEEF, do_flush: 1'b1, exp_data: 32'h0000BEEF, exp_keep: 4'b0011};
    vecs[3] = '{n: 4, bytes: 32'hDDCCBBAA, do_flush: 1'b1, exp_data: 32'hDDCCBBAA, exp_keep: 4'b1111};
    vecs[4] = '{n: 0, bytes: 32'h0,        do_flush: 1'b1, exp_data: 32'h0,        exp_keep: 4'b0000};

    fifo_wr_en = 1'b0; din = '0; flush = 1'b0; m_ready = 1'b0;
    rst = 1'b0; frst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_keep", 64'(m_keep), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; frst_n = 1'b1;

    // Back-to-back drain of 8 bytes.
    m_ready = 1'b1;
    max_run = 0;
    for (int i = 0; i < 8; i++) wr(8'h11 * 8'(i + 1));
    push_word(32'h44332211, 4'hF);
    push_word(32'h88776655, 4'hF);
    wait_idle("drain_idle", 40);
    check("drain_rd_run", 64'(max_run), 64'd8);

    // Backpressure with 12 bytes queued.
    m_ready = 1'b0;
    base = n_words;
    for (int i = 0; i < 12; i++) wr(8'h20 + 8'(i));
    push_word(32'h23222120, 4'hF);
    push_word(32'h27262524, 4'hF);
    push_word(32'h2B2A2928, 4'hF);
    repeat (20) tick();
    @(negedge clk);
    check("bp_fifo_left", 64'(fcnt), 64'd4);
    check("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    check("bp_m_valid", 64'(m_valid), 64'd1);
    check("bp_m_data", 64'(m_data), 64'h23222120);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_idle("bp_idle", 60);
    check("bp_words", 64'(n_words - base), 64'd3);

    // Table: partial words via flush, full word, flush on an empty packer.
    for (int v = 0; v < 5; v++) begin
      base = n_words;
      for (int k = 0; k < vecs[v].n; k++) wr(vecs[v].bytes[k*8 +: 8]);
      if (vecs[v].n > 0) push_word(vecs[v].exp_data, vecs[v].exp_keep);
      repeat (6) tick();
      if (vecs[v].do_flush) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      wait_idle("vec_idle", 40);
      repeat (3) tick();
      check("vec_words", 64'(n_words - base), 64'(vecs[v].n > 0 ? 1 : 0));
      check("vec_busy", 64'(busy), 64'd0);
    end

    // Flush arriving with the last captures of a full word: one full word only.
    base = n_words;
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i));
    push_word(32'h63626160, 4'hF);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("flfull_idle", 40);
    repeat (4) tick();
    check("flfull_words", 64'(n_words - base), 64'd1);

    // Write-priority collision: strobe up, nothing captured while writes continue.
    base = n_words;
    for (int i = 0; i < 6; i++) begin
      fifo_wr_en = 1'b1;
      din        = 8'h70 + 8'(i);
      @(negedge clk);
      if (i >= 1) begin
        check("col_rd_en", 64'(fifo_rd_en), 64'd1);
        check("col_busy", 64'(busy), 64'd0);
      end
      @(posedge clk); #1;
    end
    fifo_wr_en = 1'b0;
    push_word(32'h73727170, 4'hF);
    push_word(32'h00007574, 4'h3);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("col_idle", 40);
    check("col_words", 64'(n_words - base), 64'd2);

    // Reset mid-word discards the two held bytes.
    wr(8'h91);
    wr(8'h92);
    repeat (4) tick();
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_discard", 64'(sb_bytes.size()), 64'd2);
    while (sb_bytes.size() != 0) void'(sb_bytes.pop_front());
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i));
    push_word(32'hA3A2A1A0, 4'hF);
    wait_idle("midrst_idle", 40);

    // Random traffic, byte stream checked against the FIFO input.
    for (int c = 0; c < 10000; c++) begin
      fifo_wr_en = ($urandom_range(0, 99) < 45);
      din        = 8'($urandom_range(0, 255));
      m_ready    = ($urandom_range(0, 99) < 60);
      flush      = ($urandom_range(0, 99) < 3);
      tick();
    end
    fifo_wr_en = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b1;
    for (int c = 0; c < 400 && (sb_bytes.size() != 0 || busy || fcnt != 0); c++) begin
      flush = (c % 8 == 7);
      tick();
    end
    flush = 1'b0;
    repeat (4) tick();
    check("rand_left", 64'(sb_bytes.size()), 64'd0);
    check("rand_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
